// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate cache controller with true-LRU ages.
// Hit completes one cycle after acceptance; misses optionally write back the victim, then refill.
module cache_nway_wb #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int NWAYS     = 4,
  parameter int NSETS     = 128,
  parameter int WPB       = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [PA_WIDTH-1:0]      cpu_addr,
  input  logic [WRD_WIDTH-1:0]     cpu_wdata,
  input  logic [WRD_WIDTH/8-1:0]   cpu_be,
  output logic                     cpu_ready,
  output logic [WRD_WIDTH-1:0]     cpu_rdata,
  output logic                     cpu_hit,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [PA_WIDTH-1:0]      mem_addr,
  output logic [WPB*WRD_WIDTH-1:0] mem_wdata,
  input  logic [WPB*WRD_WIDTH-1:0] mem_rdata,
  input  logic                     mem_ack,
  output logic [CNT_WIDTH-1:0]     hit_cnt,
  output logic [CNT_WIDTH-1:0]     miss_cnt
);

  localparam int NBYTE = WRD_WIDTH / 8;
  localparam int BB    = $clog2(NBYTE);
  localparam int OB    = $clog2(WPB);
  localparam int IB    = $clog2(NSETS);
  localparam int TW    = PA_WIDTH - IB - OB - BB;
  localparam int AW    = $clog2(NWAYS);
  localparam int BLK   = WPB * WRD_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

  function automatic logic [NSETS-1:0][NWAYS-1:0][AW-1:0] age_init();
    logic [NSETS-1:0][NWAYS-1:0][AW-1:0] a;
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++)
        a[s][w] = AW'(w);
    return a;
  endfunction

  localparam logic [NSETS-1:0][NWAYS-1:0][AW-1:0] AGE_INIT = age_init();

  state_t                              state_q;
  logic                                we_q;
  logic [PA_WIDTH-BB-1:0]              addr_q;
  logic [WRD_WIDTH-1:0]                wdata_q;
  logic [NBYTE-1:0]                    be_q;
  logic                                miss_q;
  logic [AW-1:0]                       victim_q;
  logic [CNT_WIDTH-1:0]                hit_cnt_q;
  logic [CNT_WIDTH-1:0]                miss_cnt_q;
  logic [NSETS-1:0][NWAYS-1:0]         valid_q;
  logic [NSETS-1:0][NWAYS-1:0]         dirty_q;
  logic [NSETS-1:0][NWAYS-1:0][AW-1:0] age_q;
  logic [TW-1:0]                       tag_q  [NSETS][NWAYS];
  logic [BLK-1:0]                      data_q [NSETS][NWAYS];

  logic [TW-1:0]        tag;
  logic [IB-1:0]        idx;
  logic [OB-1:0]        off;
  logic                 lk_hit;
  logic [AW-1:0]        hit_way;
  logic                 vic_found;
  logic [AW-1:0]        vic;
  logic [BLK-1:0]       cur_blk;
  logic [BLK-1:0]       new_blk;
  logic [WRD_WIDTH-1:0] cur_word;
  logic [WRD_WIDTH-1:0] merged;
  logic                 hit_now;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[BB-1:0];
  assign off = addr_q[OB-1:0];
  assign idx = addr_q[OB +: IB];
  assign tag = addr_q[PA_WIDTH-BB-1 -: TW];

  always_comb begin
    lk_hit  = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!lk_hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
        lk_hit  = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Prefer an empty way; otherwise evict the least recently used (oldest age).
  always_comb begin
    vic_found = 1'b0;
    vic       = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!vic_found && !valid_q[idx][w]) begin
        vic_found = 1'b1;
        vic       = AW'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < NWAYS; w++)
        if (age_q[idx][w] == AW'(NWAYS - 1)) vic = AW'(w);
    end
  end

  always_comb begin
    cur_blk  = data_q[idx][hit_way];
    cur_word = cur_blk[off*WRD_WIDTH +: WRD_WIDTH];
    merged   = cur_word;
    for (int b = 0; b < NBYTE; b++)
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    new_blk = cur_blk;
    new_blk[off*WRD_WIDTH +: WRD_WIDTH] = merged;
  end

  assign hit_now   = (state_q == LOOKUP) && lk_hit;
  assign cpu_ready = hit_now;
  assign cpu_hit   = hit_now && !miss_q;
  assign cpu_rdata = hit_now ? (we_q ? merged : cur_word) : '0;
  assign mem_req   = (state_q == WRITEBACK) || (state_q == REFILL);
  assign mem_we    = (state_q == WRITEBACK);
  assign mem_wdata = (state_q == WRITEBACK) ? data_q[idx][victim_q] : '0;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    mem_addr = '0;
    if (state_q == WRITEBACK)
      mem_addr = {tag_q[idx][victim_q], idx, {(OB+BB){1'b0}}};
    else if (state_q == REFILL)
      mem_addr = {tag, idx, {(OB+BB){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      miss_q     <= 1'b0;
      victim_q   <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      age_q      <= AGE_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr[PA_WIDTH-1:BB];
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
            miss_q  <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_hit) begin
            if (we_q) dirty_q[idx][hit_way] <= 1'b1;
            for (int w = 0; w < NWAYS; w++) begin
              if (AW'(w) == hit_way)
                age_q[idx][w] <= '0;
              else if (age_q[idx][w] < age_q[idx][hit_way])
                age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
            if (!miss_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            state_q <= IDLE;
          end else begin
            miss_q   <= 1'b1;
            victim_q <= vic;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            state_q  <= (valid_q[idx][vic] && dirty_q[idx][vic]) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            dirty_q[idx][victim_q] <= 1'b0;
            state_q <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage is not reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (hit_now && we_q)
      data_q[idx][hit_way] <= new_blk;
    if (state_q == REFILL && mem_ack) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

endmodule
